// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and sizes for the response packer.
package mem_resp_pkg;
  typedef enum logic {EMPTY = 1'b0, HALF = 1'b1} state_e;
  localparam int COV_SIZE = 64;
  localparam int COV_W = 9;
  typedef struct packed {
    logic       half;
    logic [7:0] data;
  } entry_t;
endpackage

// File: rtl/mem_resp_pack_fifo.sv
// resp_fifo: DEPTH-entry synchronous FIFO of packed bytes.
module resp_fifo
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        din_i,
  output entry_t        dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);
  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   cnt_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clock) if (push_i) mem_q[wptr_q] <= din_i;
  assign dout_o  = mem_q[rptr_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/mem_resp_pack.sv
// mem_resp_pack: pairs response nibbles into bytes, buffers them, and tracks drops and state coverage.
module mem_resp_pack
  import mem_resp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             meta_reset,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  input  logic             pkt_ready,
  output logic             pkt_valid,
  output logic [7:0]       pkt_data,
  output logic             pkt_half,
  output logic [7:0]       drop_cnt,
  output logic [COV_W-1:0] coverage,
  output logic             bug
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_e          state_q, state_d;
  logic [3:0]      hold_q, hold_d, timer_q, timer_d;
  logic            prod_q, prod_d;
  entry_t          entry_q, entry_d, head;
  logic [7:0]      drop_q;
  logic            bug_q, full, empty, pop, push, drop;
  logic [CW-1:0]   fifo_cnt;
  logic [2:0]      cnt3;
  logic [5:0]      cov_idx_q;
  logic [COV_SIZE-1:0] map_q;
  logic [COV_W-1:0]    cov_q;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    prod_d  = 1'b0;
    entry_d = {1'b0, in_data, hold_q};
    if (state_q == EMPTY) begin
      if (in_valid) begin
        hold_d  = in_data;
        timer_d = '0;
        state_d = HALF;
      end
    end else if (in_valid) begin
      prod_d  = 1'b1;
      state_d = EMPTY;
    end else if (timer_q == 4'(TIMEOUT - 1)) begin
      prod_d  = 1'b1;
      entry_d = {1'b1, 4'h0, hold_q};
      state_d = EMPTY;
    end else begin
      timer_d = timer_q + 4'd1;
    end
  end
  // Produced bytes are registered once more so pkt_* never sees in_* combinationally.
  assign pop  = pkt_valid && pkt_ready;
  assign push = prod_q && (!full || pop);
  assign drop = prod_q && full && !pop;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      timer_q <= '0;
      prod_q  <= 1'b0;
      entry_q <= '0;
      drop_q  <= '0;
      bug_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      prod_q  <= prod_d;
      entry_q <= entry_d;
      drop_q  <= (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
      bug_q   <= bug_q | drop;
    end
  end
  resp_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (entry_q),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_cnt)
  );
  // The map survives reset on purpose; only meta_reset clears it.
  assign cnt3 = 3'(fifo_cnt);
  always_ff @(posedge clock) begin
    cov_idx_q <= 6'({state_q, cnt3, pkt_ready});
    if (meta_reset) begin
      map_q <= '0;
      cov_q <= '0;
    end else if (!map_q[cov_idx_q]) begin
      map_q[cov_idx_q] <= 1'b1;
      cov_q            <= cov_q + 1'b1;
    end
  end
  assign pkt_valid = !empty;
  assign pkt_data  = pkt_valid ? head.data : 8'h00;
  assign pkt_half  = pkt_valid & head.half;
  assign drop_cnt  = drop_q;
  assign coverage  = cov_q;
  assign bug       = bug_q;
endmodule

// File: tb/tb_mem_resp_pack.sv
// tb_mem_resp_pack: scoreboard bench for the nibble-to-byte packer.
module tb_mem_resp_pack;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 8;
  logic       clock = 0, reset, meta_reset, in_valid, pkt_ready;
  logic [3:0] in_data;
  logic       pkt_valid, pkt_half, bug;
  logic [7:0] pkt_data, drop_cnt;
  logic [8:0] coverage;
  logic [8:0] sb [$];
  int n_cmp = 0, n_bad = 0;
  mem_resp_pack #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .meta_reset(meta_reset), .in_valid(in_valid),
    .in_data(in_data), .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .pkt_half(pkt_half), .drop_cnt(drop_cnt), .coverage(coverage), .bug(bug)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic nib(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    pkt_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain_left", sb.size(), 0);
    tick();
    chk("drain_empty", pkt_valid, 0);
  endtask
  // Every accepted head is checked against the oldest expected byte.
  always @(negedge clock) begin
    if (reset && pkt_valid && pkt_ready) begin
      chk("pop_expected", sb.size() != 0, 1);
      if (sb.size() != 0) chk("pkt", {pkt_half, pkt_data}, sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] lo, d;
    reset = 0; meta_reset = 0; in_valid = 0; in_data = 0; pkt_ready = 0;
    tick(); tick();
    chk("rst_valid", pkt_valid, 0);
    chk("rst_data", pkt_data, 0);
    chk("rst_half", pkt_half, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_bug", bug, 0);
    reset = 1;
    meta_reset = 1;
    tick();
    meta_reset = 0;
    chk("meta_clear", coverage, 0);
    tick();
    chk("meta_first", coverage, 1);
    tick(); tick();
    chk("cov_steady", coverage, 1);
    pkt_ready = 1;
    nib(4'h3);
    sb.push_back({1'b0, 8'hA3});
    nib(4'hA);
    chk("pair_lat0", pkt_valid, 0);
    tick();
    chk("pair_valid", pkt_valid, 1);
    chk("pair_data", pkt_data, 8'hA3);
    chk("pair_half", pkt_half, 0);
    tick();
    chk("pair_gone", pkt_valid, 0);
    sb.push_back({1'b1, 8'h05});
    nib(4'h5);
    repeat (TIMEOUT) tick();
    chk("to_early", pkt_valid, 0);
    tick();
    chk("to_valid", pkt_valid, 1);
    chk("to_data", pkt_data, 8'h05);
    chk("to_half", pkt_half, 1);
    chk("to_fsm", dut.state_q, 0);
    tick();
    nib(4'h5);
    repeat (TIMEOUT - 1) tick();
    sb.push_back({1'b0, 8'hC5});
    nib(4'hC);
    tick();
    chk("race_valid", pkt_valid, 1);
    chk("race_data", pkt_data, 8'hC5);
    chk("race_half", pkt_half, 0);
    repeat (TIMEOUT + 3) tick();
    chk("race_noflush", pkt_valid, 0);
    pkt_ready = 0;
    for (int i = 0; i < 12; i++) begin
      d = 4'(i * 3 + 1);
      if (i % 2 == 0) lo = d;
      else if (i < 8) sb.push_back({1'b0, d, lo});
      nib(d);
    end
    tick(); tick();
    chk("ovf_drop", drop_cnt, 2);
    chk("ovf_bug", bug, 1);
    chk("ovf_count", dut.fifo_cnt, 4);
    drain();
    pkt_ready = 0;
    for (int i = 0; i < 8; i++) begin
      d = 4'(i + 8);
      if (i % 2 == 0) lo = d;
      else sb.push_back({1'b0, d, lo});
      nib(d);
    end
    tick();
    chk("full_count", dut.fifo_cnt, 4);
    sb.push_back({1'b0, 8'h2E});
    nib(4'hE);
    nib(4'h2);
    pkt_ready = 1;
    tick();
    pkt_ready = 0;
    chk("fpop_count", dut.fifo_cnt, 4);
    chk("fpop_drop", drop_cnt, 2);
    drain();
    pkt_ready = 0;
    for (int i = 0; i < 4; i++) begin
      d = 4'(i + 1);
      if (i % 2 == 0) lo = d;
      else sb.push_back({1'b0, d, lo});
      nib(d);
    end
    nib(4'h7);
    tick();
    chk("mid_count", dut.fifo_cnt, 2);
    #2 reset = 0;
    sb.delete();
    #1;
    chk("arst_valid", pkt_valid, 0);
    tick(); tick();
    reset = 1;
    pkt_ready = 1;
    repeat (TIMEOUT + 4) tick();
    chk("arst_noflush", pkt_valid, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_bug", bug, 0);
    pkt_ready = 0;
    meta_reset = 1;
    tick();
    meta_reset = 0;
    chk("meta2_clear", coverage, 0);
    tick();
    chk("meta2_first", coverage, 1);
    chk("sb_final", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
